mul8u_dot_accum: RTL and testbench
==================================

Name: mul8u_dot_accum

Overview:
- Sequential accumulator stage directly downstream of the combinational 8x8 unsigned approximate multipliers (mul8u_* family, 16-bit product output).
- Sums a stream of 16-bit products into a dot-product result and emits it through a valid/ready output.
- Lets the team measure accumulated approximation error and energy for vector workloads.
- The multiplier output drives in_prod directly. There is no register between the multiplier and this block.

Parameters:
- ACC_W, 24, accumulator and out_sum width. Legal range 17..32.
- CNT_W, 8, width of the element counter out_count.
- SATURATE, 1. 1 = clamp the sum to all-ones on overflow; 0 = sum wraps modulo 2^ACC_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_prod/in_last are valid this cycle.
- in_ready  out  1  block can accept a beat.
- in_prod  in  16  unsigned product from the multiplier.
- in_last  in  1  marks the final element of the current vector.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_sum  out  ACC_W  accumulated sum of the vector.
- out_count  out  CNT_W  number of elements in the vector, saturating.
- out_ovf  out  1  sticky flag: the exact sum exceeded 2^ACC_W-1 during this vector.

Behaviour:
- Reset (asynchronous, any time, including mid-vector or while HOLD):
  - state=IDLE, acc=0, cnt=0, ovf=0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1.
  - Any partial vector is discarded.
- Beat accepted when in_valid & in_ready, sampled at the rising edge.
- States:
  - IDLE: no vector in progress.
    - Accept with in_last=0: acc<=in_prod, cnt<=1, ovf<=0, go to ACCUM.
    - Accept with in_last=1: load the output registers directly with sum=in_prod, count=1, ovf=0; go to HOLD.
  - ACCUM: vector in progress.
    - Accept: compute next = acc + in_prod in ACC_W+1 bits.
    - If the carry bit is set: ovf<=1, and acc<=all-ones (SATURATE=1) or next[ACC_W-1:0] (SATURATE=0).
    - Otherwise acc<=next[ACC_W-1:0].
    - cnt<=cnt+1, held at 2^CNT_W-1 once reached.
    - With in_last=1: the output registers take the updated acc/cnt/ovf values; go to HOLD.
    - With in_valid=0: hold all state; no timeout.
  - HOLD: result presented.
    - out_valid=1, in_ready=0.
    - out_sum/out_count/out_ovf stay stable while out_valid & !out_ready.
    - out_valid & out_ready: out_valid<=0 and go to IDLE. in_ready is 1 from the next cycle.
    - The internal acc/cnt/ovf are cleared on this transition.
- Once in SATURATE=1 with ovf=1, acc stays at all-ones for the rest of the vector.
- Latency: out_valid rises 1 cycle after the in_last beat is accepted.
- Throughput: one beat per cycle inside a vector. Each vector costs at least 1 extra cycle, the HOLD/handshake cycle.
- in_ready is a registered, state-based signal. It has no combinational path from out_ready.
- Arithmetic is unsigned only. The outputs hold their last values after the handshake until the next load.

Test Plan:
- in_prod 100,200,300 on consecutive cycles, in_last on 300, out_ready=1 → out_valid one cycle after the last beat; out_sum=600, out_count=3, out_ovf=0; in_ready back to 1 after the handshake.
- Single beat in_prod=65535 with in_last=1 → out_sum=65535, out_count=1, out_ovf=0.
- ACC_W=24, SATURATE=1, 257 beats of 65535 (exact sum 16842495) → out_sum=16777215, out_ovf=1, out_count=255 (CNT_W=8, saturated).
- Same 257-beat stimulus with SATURATE=0 → out_sum=65279 (16842495 mod 2^24), out_ovf=1, out_count=255.
- Backpressure: result 600 pending with out_ready=0 for 5 cycles → out_valid=1 and out_sum=600 stable, in_ready=0, no beats accepted. out_ready=1 → handshake, then IDLE.
- rst pulsed asynchronously (mid-cycle) after 2 of 3 beats → all outputs 0 immediately. A following vector 7,8 (in_last on 8) gives out_sum=15, out_count=2, with no residue from the aborted vector.

Source files
------------

// File: rtl/mul8u_dot_accum.sv
// mul8u_dot_accum: sums a stream of 16-bit unsigned products from an
// approximate 8x8 multiplier into a dot-product result and presents it
// through a valid/ready output. Overflow either clamps or wraps.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no vector in progress, waiting for the first beat
// S_ACCUM | vector in progress, summing beats until in_last
// S_HOLD  | result presented on out_*, waiting for out_ready
module mul8u_dot_accum #(
    parameter int ACC_W    = 24,
    parameter int CNT_W    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ovf, ovf_nxt;

    logic             load_out;
    logic [ACC_W-1:0] sum_ld;
    logic [CNT_W-1:0] cnt_ld;
    logic             ovf_ld;

    logic             accept;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   sum_ext;
    logic [CNT_W-1:0] cnt_inc;

    assign accept   = in_valid & in_ready;
    assign prod_ext = {{(ACC_W-16){1'b0}}, in_prod};
    // One extra bit so the carry out of the accumulator is the overflow flag.
    assign sum_ext  = {1'b0, acc} + {1'b0, prod_ext};
    assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    // Next-state, accumulator update and output-register load decode.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        load_out  = 1'b0;
        sum_ld    = '0;
        cnt_ld    = '0;
        ovf_ld    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (in_last) begin
                        // Single-element vector bypasses the accumulator.
                        load_out  = 1'b1;
                        sum_ld    = prod_ext;
                        cnt_ld    = CNT_W'(1);
                        ovf_ld    = 1'b0;
                        state_nxt = S_HOLD;
                    end else begin
                        acc_nxt   = prod_ext;
                        cnt_nxt   = CNT_W'(1);
                        ovf_nxt   = 1'b0;
                        state_nxt = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    cnt_nxt = cnt_inc;
                    if (sum_ext[ACC_W]) begin
                        ovf_nxt = 1'b1;
                        if (SATURATE) acc_nxt = {ACC_W{1'b1}};
                        else          acc_nxt = sum_ext[ACC_W-1:0];
                    end else begin
                        acc_nxt = sum_ext[ACC_W-1:0];
                    end
                    if (in_last) begin
                        load_out  = 1'b1;
                        sum_ld    = acc_nxt;
                        cnt_ld    = cnt_nxt;
                        ovf_ld    = ovf_nxt;
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    // Handshake flags registered from the next state so in_ready never
    // depends combinationally on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nxt != S_HOLD);
            out_valid <= (state_nxt == S_HOLD);
        end
    end

    // Result registers: loaded on the last beat, otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (load_out) begin
            out_sum   <= sum_ld;
            out_count <= cnt_ld;
            out_ovf   <= ovf_ld;
        end
    end

endmodule

// File: tb/tb_mul8u_dot_accum.sv
// Bench for mul8u_dot_accum: a saturating and a wrapping instance share the
// same stimulus and are checked every cycle against an exact-sum model.
module tb_mul8u_dot_accum;

    localparam int     ACC_W = 24;
    localparam int     CNT_W = 8;
    localparam longint MAXV  = (64'd1 << ACC_W) - 1;
    localparam int     CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_prod = '0;

    logic             s_in_ready, s_out_valid, s_out_ovf;
    logic [ACC_W-1:0] s_out_sum;
    logic [CNT_W-1:0] s_out_count;
    logic             w_in_ready, w_out_valid, w_out_ovf;
    logic [ACC_W-1:0] w_out_sum;
    logic [CNT_W-1:0] w_out_count;

    mul8u_dot_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_prod(in_prod), .in_last(in_last), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_sum(s_out_sum), .out_count(s_out_count),
        .out_ovf(s_out_ovf));

    mul8u_dot_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_prod(in_prod), .in_last(in_last), .out_valid(w_out_valid),
        .out_ready(out_ready), .out_sum(w_out_sum), .out_count(w_out_count),
        .out_ovf(w_out_ovf));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int rdy_pct = 100;
    bit run_cmp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: exact running sum of the vector; outputs derived by
    // clamping, modulo and comparison against the accumulator range.
    bit     m_hold, m_in_vec;
    longint m_exact;
    int     m_n;
    longint e_sum_sat, e_sum_wrap;
    int     e_cnt;
    bit     e_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hold = 0; m_in_vec = 0; m_exact = 0; m_n = 0;
            e_sum_sat = 0; e_sum_wrap = 0; e_cnt = 0; e_ovf = 0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 0;
        end else if (in_valid) begin
            if (!m_in_vec) begin m_exact = 0; m_n = 0; end
            m_exact += longint'(in_prod);
            m_n++;
            if (in_last) begin
                e_sum_sat  = (m_exact > MAXV) ? MAXV : m_exact;
                e_sum_wrap = m_exact % (MAXV + 1);
                e_cnt      = (m_n > CMAX) ? CMAX : m_n;
                e_ovf      = (m_exact > MAXV);
                m_hold     = 1;
                m_in_vec   = 0;
            end else begin
                m_in_vec = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("sat_in_ready",   s_in_ready,  !m_hold);
            chk("wrap_in_ready",  w_in_ready,  !m_hold);
            chk("sat_out_valid",  s_out_valid, m_hold);
            chk("wrap_out_valid", w_out_valid, m_hold);
            chk("sat_out_sum",    s_out_sum,   e_sum_sat);
            chk("wrap_out_sum",   w_out_sum,   e_sum_wrap);
            chk("sat_out_count",  s_out_count, e_cnt);
            chk("wrap_out_count", w_out_count, e_cnt);
            chk("sat_out_ovf",    s_out_ovf,   e_ovf);
            chk("wrap_out_ovf",   w_out_ovf,   e_ovf);
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready = ($urandom_range(99) < rdy_pct);
    end

    task automatic send_beat(input logic [15:0] p, input bit last);
        bit acc;
        int waited;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = last;
        waited   = 0;
        do begin
            @(negedge clk);
            acc = s_in_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!acc && waited < 1000);
        if (!acc) chk("beat_accept_timeout", 0, 1);
    endtask

    task automatic expect_result(input string tag, input longint s_sat, input longint s_wrap,
                                 input int cnt, input bit ovf);
        int w;
        w = 0;
        while (w < 64) begin
            @(negedge clk);
            if (s_out_valid) break;
            w++;
        end
        chk({tag, "_latency"},  w, 0);
        chk({tag, "_sat_sum"},  s_out_sum, s_sat);
        chk({tag, "_wrap_sum"}, w_out_sum, s_wrap);
        chk({tag, "_count"},    s_out_count, cnt);
        chk({tag, "_wcount"},   w_out_count, cnt);
        chk({tag, "_ovf"},      s_out_ovf, ovf);
        chk({tag, "_wovf"},     w_out_ovf, ovf);
        chk({tag, "_model_sum"}, e_sum_sat, s_sat);
        chk({tag, "_model_wsum"}, e_sum_wrap, s_wrap);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", s_out_valid, 0);
        chk("rst_in_ready",  s_in_ready, 1);
        chk("rst_out_sum",   s_out_sum, 0);
        chk("rst_out_count", w_out_count, 0);
        chk("rst_out_ovf",   s_out_ovf, 0);
        #11 rst = 1'b0;
        run_cmp = 1'b1;
        @(posedge clk); #1;

        rdy_pct = 100;
        send_beat(100, 0); send_beat(200, 0); send_beat(300, 1);
        in_valid = 0;
        expect_result("v3", 600, 600, 3, 0);
        @(posedge clk); #1;
        chk("v3_ready_after_hs", s_in_ready, 1);

        send_beat(16'hFFFF, 1);
        in_valid = 0;
        expect_result("single", 65535, 65535, 1, 0);

        for (int i = 0; i < 257; i++) send_beat(16'hFFFF, i == 256);
        in_valid = 0;
        expect_result("b257", 16777215, 65279, 255, 1);

        rdy_pct = 0;
        @(posedge clk); #2;
        send_beat(100, 0); send_beat(200, 0); send_beat(300, 1);
        in_valid = 1; in_prod = 9; in_last = 1;
        expect_result("bp", 600, 600, 3, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", s_out_valid, 1);
            chk("bp_out_sum",   s_out_sum, 600);
            chk("bp_in_ready",  s_in_ready, 0);
        end
        rdy_pct = 100;
        send_beat(9, 1);
        in_valid = 0;
        expect_result("after_bp", 9, 9, 1, 0);

        send_beat(50, 0); send_beat(60, 0);
        in_valid = 0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_out_sum",   s_out_sum, 0);
        chk("arst_out_wsum",  w_out_sum, 0);
        chk("arst_out_count", s_out_count, 0);
        chk("arst_out_valid", s_out_valid, 0);
        chk("arst_in_ready",  s_in_ready, 1);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        send_beat(7, 0); send_beat(8, 1);
        in_valid = 0;
        expect_result("post_rst", 15, 15, 2, 0);

        rdy_pct = 60;
        for (int v = 0; v < 60; v++) begin
            int len;
            len = ($urandom_range(9) == 0) ? int'($urandom_range(300, 250))
                                           : int'($urandom_range(12, 1));
            for (int i = 0; i < len; i++) begin
                logic [15:0] p;
                if ($urandom_range(3) == 0) begin
                    in_valid = 0;
                    repeat ($urandom_range(3, 1)) @(posedge clk);
                    #1;
                end
                p = ($urandom_range(2) == 0) ? 16'hFFFF - 16'($urandom_range(15))
                                             : 16'($urandom_range(65535));
                send_beat(p, i == len - 1);
            end
            in_valid = 0;
        end
        rdy_pct = 100;
        repeat (6) @(posedge clk);
        #1;
        chk("final_idle_ready", s_in_ready, 1);

        run_cmp = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
